axil_regfile_selftest_master: RTL and testbench

AXIL_REGFILE_SELFTEST_MASTER -- requirements
Module: axil_regfile_selftest_master

---
 rtl/axil_regfile_selftest_master.sv | 145 ++++++++++++++
 tb/tb_axil_regfile_selftest_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_regfile_selftest_master.sv
// axil_regfile_selftest_master: AXI4-Lite master that writes seed+i to each register, then reads back and counts errors
module axil_regfile_selftest_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_REGS = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = 32'h0000_0000
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   seed,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [7:0]                      err_cnt,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [3:0] LAST = 4'(C_NUM_REGS - 1);

  logic [2:0]    state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [DW-1:0] seed_q, seed_d, wdata_q, wdata_d;
  logic [AW-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [7:0]    err_q, err_d;
  logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic          bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  logic [3:0]    nidx;
  logic [AW-1:0] naddr;
  logic [7:0]    err_inc;
  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs, last;

  assign nidx    = idx_q + 4'd1;
  assign naddr   = C_BASE_ADDR + AW'({nidx, 2'b00});
  assign err_inc = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
  assign aw_hs   = awvalid_q & M_AXI_AWREADY;
  assign w_hs    = wvalid_q & M_AXI_WREADY;
  assign b_hs    = bready_q & M_AXI_BVALID;
  assign ar_hs   = arvalid_q & M_AXI_ARREADY;
  assign r_hs    = rready_q & M_AXI_RVALID;
  assign last    = idx_q == LAST;

  // Sequencer: every VALID/READY and status output is computed here and registered below
  always_comb begin
    state_d = state_q; idx_d = idx_q; seed_d = seed_q; wdata_d = wdata_q;
    awaddr_d = awaddr_q; araddr_d = araddr_q; err_d = err_q;
    awvalid_d = awvalid_q; wvalid_d = wvalid_q; aw_done_d = aw_done_q; w_done_d = w_done_q;
    bready_d = bready_q; arvalid_d = arvalid_q; rready_d = rready_q;
    busy_d = busy_q; done_d = 1'b0; pass_d = pass_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_WR_REQ; idx_d = '0; err_d = '0; pass_d = 1'b0; busy_d = 1'b1;
        seed_d = seed; wdata_d = seed; awaddr_d = C_BASE_ADDR;
        awvalid_d = 1'b1; wvalid_d = 1'b1; aw_done_d = 1'b0; w_done_d = 1'b0;
      end
      S_WR_REQ: begin
        if (aw_hs) begin awvalid_d = 1'b0; aw_done_d = 1'b1; end
        if (w_hs) begin wvalid_d = 1'b0; w_done_d = 1'b1; end
        if ((aw_hs | aw_done_q) & (w_hs | w_done_q)) begin state_d = S_WR_RESP; bready_d = 1'b1; end
      end
      S_WR_RESP: if (b_hs) begin
        bready_d = 1'b0;
        if (M_AXI_BRESP != 2'b00) err_d = err_inc;
        if (last) begin
          state_d = S_RD_REQ; idx_d = '0; arvalid_d = 1'b1; araddr_d = C_BASE_ADDR;
        end else begin
          state_d = S_WR_REQ; idx_d = nidx; awaddr_d = naddr; wdata_d = seed_q + DW'(nidx);
          awvalid_d = 1'b1; wvalid_d = 1'b1; aw_done_d = 1'b0; w_done_d = 1'b0;
        end
      end
      S_RD_REQ: if (ar_hs) begin state_d = S_RD_DATA; arvalid_d = 1'b0; rready_d = 1'b1; end
      S_RD_DATA: if (r_hs) begin
        rready_d = 1'b0;
        if ((M_AXI_RDATA != seed_q + DW'(idx_q)) || (M_AXI_RRESP != 2'b00)) err_d = err_inc;
        if (last) begin
          state_d = S_DONE; done_d = 1'b1; busy_d = 1'b0; pass_d = (err_d == 8'd0);
        end else begin
          state_d = S_RD_REQ; idx_d = nidx; araddr_d = naddr; arvalid_d = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any pass in flight
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= S_IDLE; idx_q <= '0; seed_q <= '0; wdata_q <= '0;
      awaddr_q <= C_BASE_ADDR; araddr_q <= C_BASE_ADDR; err_q <= '0;
      awvalid_q <= 1'b0; wvalid_q <= 1'b0; aw_done_q <= 1'b0; w_done_q <= 1'b0;
      bready_q <= 1'b0; arvalid_q <= 1'b0; rready_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; pass_q <= 1'b0;
    end else begin
      state_q <= state_d; idx_q <= idx_d; seed_q <= seed_d; wdata_q <= wdata_d;
      awaddr_q <= awaddr_d; araddr_q <= araddr_d; err_q <= err_d;
      awvalid_q <= awvalid_d; wvalid_q <= wvalid_d; aw_done_q <= aw_done_d; w_done_q <= w_done_d;
      bready_q <= bready_d; arvalid_q <= arvalid_d; rready_q <= rready_d;
      busy_q <= busy_d; done_q <= done_d; pass_q <= pass_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_axil_regfile_selftest_master.sv
// tb_axil_regfile_selftest_master: directed checks of the self-test master against a small AXI4-Lite slave model
module tb_axil_regfile_selftest_master;
  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic [31:0] seed = '0;
  logic        busy, done, pass;
  logic [7:0]  err_cnt;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  axil_regfile_selftest_master dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  always #5 ACLK = ~ACLK;

  // Slave configuration, set by the stimulus
  int   aw_delay = 0;
  logic stuck_en = 1'b0;
  logic slverr_en = 1'b0;

  // Slave state
  logic [31:0] mem [4];
  logic [31:0] rd_log [4];
  int          wr_cnt [4];
  logic        aw_got, w_got;
  logic [31:0] aw_a, w_d;
  logic [1:0]  ridx;
  int          aw_wait;
  logic        have_a, have_w;
  logic [31:0] cur_a, cur_d;

  assign awready = awvalid && (aw_wait >= aw_delay);
  assign wready  = 1'b1;
  assign arready = 1'b1;
  assign have_a  = (awvalid && awready) || aw_got;
  assign have_w  = (wvalid && wready) || w_got;
  assign cur_a   = (awvalid && awready) ? awaddr : aw_a;
  assign cur_d   = (wvalid && wready) ? wdata : w_d;

  initial begin
    for (int i = 0; i < 4; i++) begin mem[i] = '0; rd_log[i] = '0; wr_cnt[i] = 0; end
  end

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_got <= 1'b0; w_got <= 1'b0; aw_a <= '0; w_d <= '0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
      ridx <= 2'd0; aw_wait <= 0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      if (bvalid && bready) bvalid <= 1'b0;
      if (have_a && have_w && !bvalid) begin
        mem[cur_a[3:2]] <= cur_d;
        wr_cnt[cur_a[3:2]] <= wr_cnt[cur_a[3:2]] + 1;
        bvalid <= 1'b1;
        bresp <= (slverr_en && cur_a == 32'h4) ? 2'b10 : 2'b00;
        aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        aw_got <= have_a; w_got <= have_w; aw_a <= cur_a; w_d <= cur_d;
      end
      if (rvalid && rready) begin rvalid <= 1'b0; rd_log[ridx] <= rdata; end
      if (arvalid && arready) begin
        rvalid <= 1'b1; ridx <= araddr[3:2]; rresp <= 2'b00;
        rdata <= mem[araddr[3:2]] & ((stuck_en && araddr[3:2] == 2'd2) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
      end
    end
  end

  // Free-running activity counters; the stimulus compares deltas
  int done_cnt = 0, awv_cyc = 0, wv_cyc = 0, b_cnt = 0, r_cnt = 0;
  always @(negedge ACLK) begin
    done_cnt <= done_cnt + int'(done);
    awv_cyc  <= awv_cyc + int'(awvalid);
    wv_cyc   <= wv_cyc + int'(wvalid);
    b_cnt    <= b_cnt + int'(bvalid && bready);
    r_cnt    <= r_cnt + int'(rvalid && rready);
  end

  int checks = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [31:0] s);
    @(negedge ACLK); start = 1'b1; seed = s;
    @(negedge ACLK); start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge ACLK);
      if (done) ok = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(ok), 32'd1);
  endtask

  int d0, aw0, w0, b0, r0;
  int wc0 [4];

  task automatic snap();
    d0 = done_cnt; aw0 = awv_cyc; w0 = wv_cyc; b0 = b_cnt; r0 = r_cnt;
    for (int i = 0; i < 4; i++) wc0[i] = wr_cnt[i];
  endtask

  initial begin
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_valids", {29'd0, awvalid, wvalid, arvalid}, 0);
    chk("rst_readys", {30'd0, bready, rready}, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_ties", {22'd0, awprot, arprot, wstrb}, 32'h0000_000F);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;

    // Ideal slave, seed 1
    snap();
    pulse_start(32'h1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_first_aw", {awvalid, wvalid, 30'd0}, 32'hC000_0000);
    chk("t1_awaddr0", awaddr, 32'h0);
    chk("t1_wdata0", wdata, 32'h1);
    wait_done("t1");
    chk("t1_pass", 32'(pass), 1);
    chk("t1_err", 32'(err_cnt), 0);
    chk("t1_busy_done", 32'(busy), 0);
    @(negedge ACLK);
    chk("t1_done_one_cycle", 32'(done), 0);
    chk("t1_done_cnt", 32'(done_cnt - d0), 1);
    chk("t1_mem0", mem[0], 32'h1);
    chk("t1_mem1", mem[1], 32'h2);
    chk("t1_mem2", mem[2], 32'h3);
    chk("t1_mem3", mem[3], 32'h4);
    chk("t1_b_cnt", 32'(b_cnt - b0), 4);
    chk("t1_r_cnt", 32'(r_cnt - r0), 4);

    // Register 2 bit 0 stuck low
    stuck_en = 1'b1;
    snap();
    pulse_start(32'h1);
    wait_done("t2");
    chk("t2_pass", 32'(pass), 0);
    chk("t2_err", 32'(err_cnt), 1);
    chk("t2_rd8", rd_log[2], 32'h2);
    @(negedge ACLK);
    stuck_en = 1'b0;

    // SLVERR on the write to 0x4 only
    slverr_en = 1'b1;
    snap();
    pulse_start(32'h1);
    wait_done("t3");
    chk("t3_pass", 32'(pass), 0);
    chk("t3_err", 32'(err_cnt), 1);
    @(negedge ACLK);
    chk("t3_b_cnt", 32'(b_cnt - b0), 4);
    chk("t3_r_cnt", 32'(r_cnt - r0), 4);
    slverr_en = 1'b0;

    // AWREADY delayed three cycles, WREADY immediate
    aw_delay = 3;
    snap();
    pulse_start(32'h10);
    wait_done("t4");
    chk("t4_pass", 32'(pass), 1);
    @(negedge ACLK);
    chk("t4_awv_cycles", 32'(awv_cyc - aw0), 16);
    chk("t4_wv_cycles", 32'(wv_cyc - w0), 4);
    chk("t4_b_cnt", 32'(b_cnt - b0), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_wr_once%0d", i), 32'(wr_cnt[i] - wc0[i]), 1);
    chk("t4_mem3", mem[3], 32'h13);
    aw_delay = 0;

    // start during RD_DATA is ignored, then reset during the read of 0x8
    snap();
    pulse_start(32'h1);
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin @(negedge ACLK); if (rready) ok = 1'b1; end
      chk("t5_rd_data_seen", 32'(ok), 1);
    end
    start = 1'b1; seed = 32'h55;
    @(negedge ACLK);
    start = 1'b0;
    chk("t5_ign_awvalid", 32'(awvalid), 0);
    chk("t5_ign_arvalid", 32'(arvalid), 1);
    chk("t5_ign_araddr", araddr, 32'h4);
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
        if (arvalid && araddr == 32'h8) ok = 1'b1; else @(negedge ACLK);
      end
      chk("t5_rd8_seen", 32'(ok), 1);
    end
    ARESETN = 1'b0;
    #1;
    chk("t5_rst_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_araddr", araddr, 32'h0);
    repeat (3) @(negedge ACLK);
    chk("t5_no_done", 32'(done_cnt - d0), 0);
    ARESETN = 1'b1;

    // Fresh pass after reset, data wraps
    snap();
    pulse_start(32'hFFFF_FFFF);
    wait_done("t6");
    chk("t6_pass", 32'(pass), 1);
    chk("t6_err", 32'(err_cnt), 0);
    @(negedge ACLK);
    chk("t6_done_cnt", 32'(done_cnt - d0), 1);
    chk("t6_mem0", mem[0], 32'hFFFF_FFFF);
    chk("t6_mem1", mem[1], 32'h0);
    chk("t6_mem2", mem[2], 32'h1);
    chk("t6_mem3", mem[3], 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
